// File: rtl/e_mdu_pkg.sv
// Opcode constants and default latencies shared by the E-stage MDU and the decoder.
package e_mdu_pkg;

   localparam logic [3:0] MDU_NOP   = 4'd0;
   localparam logic [3:0] MDU_MULT  = 4'd1;
   localparam logic [3:0] MDU_MULTU = 4'd2;
   localparam logic [3:0] MDU_DIV   = 4'd3;
   localparam logic [3:0] MDU_DIVU  = 4'd4;
   localparam logic [3:0] MDU_MFHI  = 4'd5;
   localparam logic [3:0] MDU_MFLO  = 4'd6;
   localparam logic [3:0] MDU_MTHI  = 4'd7;
   localparam logic [3:0] MDU_MTLO  = 4'd8;

   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   // Latency counter must hold the larger cycle count, never narrower than 4 bits.
   function automatic int cnt_width(input int m, input int d);
      int mx;
      int w;
      mx = (m > d) ? m : d;
      w  = $clog2(mx + 1);
      return (w < 4) ? 4 : w;
   endfunction

endpackage

// File: rtl/e_mdu.sv
// Multi-cycle multiply/divide unit: result computed at start, held in pending
// registers, and committed to HI/LO when the latency counter expires.
module e_mdu
   import e_mdu_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [3:0]  mdu_opcode,
   input  logic        start,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo,
   output logic [31:0] result
);

   localparam int CW = cnt_width(MULT_CYCLES, DIV_CYCLES);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_BUSY = 1'b1;

   logic [0:0]    state;
   logic [CW-1:0] cnt;
   logic [31:0]   pend_hi;
   logic [31:0]   pend_lo;
   logic          pend_we;

   logic [63:0]   prod_s;
   logic [63:0]   prod_u;
   logic [31:0]   nxt_hi;
   logic [31:0]   nxt_lo;
   logic          nxt_we;

   assign prod_s = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
   assign prod_u = {32'd0, a} * {32'd0, b};

   always_comb begin
      nxt_hi = hi;
      nxt_lo = lo;
      nxt_we = 1'b1;
      case (mdu_opcode)
         MDU_MULT:  {nxt_hi, nxt_lo} = prod_s;
         MDU_MULTU: {nxt_hi, nxt_lo} = prod_u;
         MDU_DIV: begin
            if (b == 32'd0) begin
               nxt_we = 1'b0;
            end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
               // The one quotient that overflows; pinned rather than left to the operator.
               nxt_lo = 32'h8000_0000;
               nxt_hi = 32'd0;
            end else begin
               nxt_lo = $signed(a) / $signed(b);
               nxt_hi = $signed(a) % $signed(b);
            end
         end
         MDU_DIVU: begin
            if (b == 32'd0) begin
               nxt_we = 1'b0;
            end else begin
               nxt_lo = a / b;
               nxt_hi = a % b;
            end
         end
         default: nxt_we = 1'b0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= S_IDLE;
         cnt     <= '0;
         hi      <= '0;
         lo      <= '0;
         pend_hi <= '0;
         pend_lo <= '0;
         pend_we <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               if (start) begin
                  case (mdu_opcode)
                     MDU_MULT, MDU_MULTU, MDU_DIV, MDU_DIVU: begin
                        pend_hi <= nxt_hi;
                        pend_lo <= nxt_lo;
                        pend_we <= nxt_we;
                        cnt     <= (mdu_opcode == MDU_DIV || mdu_opcode == MDU_DIVU) ?
                                   CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
                        state   <= S_BUSY;
                     end
                     MDU_MTHI: hi <= a;
                     MDU_MTLO: lo <= a;
                     default: ;
                  endcase
               end
            end
            default: begin
               // Start while busy is ignored; only the counter advances.
               if (cnt <= CW'(1)) begin
                  cnt   <= '0;
                  state <= S_IDLE;
                  if (pend_we) begin
                     hi <= pend_hi;
                     lo <= pend_lo;
                  end
               end else begin
                  cnt <= cnt - CW'(1);
               end
            end
         endcase
      end
   end

   assign busy = (state == S_BUSY);

   always_comb begin
      result = 32'd0;
      if (mdu_opcode == MDU_MFHI) result = hi;
      else if (mdu_opcode == MDU_MFLO) result = lo;
   end

endmodule

// File: tb/tb_e_mdu.sv
// Scoreboard bench for e_mdu: expected HI/LO queued at issue, checked when busy drops.
module tb_e_mdu;
   import e_mdu_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        start = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic [3:0]  mdu_opcode = MDU_NOP;
   logic        busy;
   logic [31:0] hi, lo, result;

   int passed = 0;
   int total  = 0;
   logic [63:0] sb_q[$];
   logic [63:0] m_hilo = '0;

   always #5 clk = ~clk;

   e_mdu dut (
      .clk(clk), .reset(reset), .a(a), .b(b), .mdu_opcode(mdu_opcode),
      .start(start), .busy(busy), .hi(hi), .lo(lo), .result(result)
   );

   function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] x,
                                         input logic [31:0] y, input logic [63:0] cur);
      longint sx, sy, q, r;
      longint unsigned ux, uy, uq, ur;
      sx = longint'($signed(x));
      sy = longint'($signed(y));
      ux = {32'd0, x};
      uy = {32'd0, y};
      case (op)
         MDU_MULT:  return 64'(sx * sy);
         MDU_MULTU: return 64'(ux * uy);
         MDU_DIV: begin
            if (y == 0) return cur;
            q = sx / sy; r = sx % sy;
            return {r[31:0], q[31:0]};
         end
         MDU_DIVU: begin
            if (y == 0) return cur;
            uq = ux / uy; ur = ux % uy;
            return {ur[31:0], uq[31:0]};
         end
         default: return cur;
      endcase
   endfunction

   // Called at a negedge; returns at the negedge after the sampling edge with operands scrambled.
   task automatic issue(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      mdu_opcode = op; a = x; b = y; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0; mdu_opcode = MDU_NOP; a = $urandom; b = $urandom;
   endtask

   task automatic push_exp(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y,
                           input logic [63:0] exp);
      m_hilo = exp;
      sb_q.push_back(exp);
      issue(op, x, y);
   endtask

   task automatic push_model(input logic [3:0] op, input logic [31:0] x, input logic [31:0] y);
      m_hilo = model(op, x, y, m_hilo);
      sb_q.push_back(m_hilo);
      issue(op, x, y);
   endtask

   // Counts busy cycles, checks HI/LO hold, pops the scoreboard. inj=1 pokes ignored ops.
   task automatic wait_done(input string name, input int n, input bit inj);
      int cnt = 0;
      bit hold_ok = 1'b1;
      logic [63:0] old, e;
      old = {hi, lo};
      while (busy === 1'b1 && cnt < 40) begin
         cnt++;
         if ({hi, lo} !== old) hold_ok = 1'b0;
         if (inj && cnt == 2) begin mdu_opcode = MDU_MTLO; a = 32'hDEAD_BEEF; start = 1'b1; end
         if (inj && cnt == 3) begin mdu_opcode = MDU_MULT; a = 32'd100; b = 32'd100; end
         if (inj && cnt == 4) begin start = 1'b0; mdu_opcode = MDU_NOP; end
         @(negedge clk);
      end
      total++;
      if (cnt !== n) $display("FAIL %s busy_len got %0d want %0d", name, cnt, n);
      else passed++;
      total++;
      if (!hold_ok) $display("FAIL %s hilo_hold changed during busy, old %h", name, old);
      else passed++;
      total++;
      if (sb_q.size() == 0) begin
         $display("FAIL %s scoreboard empty, got %h", name, {hi, lo});
      end else begin
         e = sb_q.pop_front();
         if ({hi, lo} !== e) $display("FAIL %s hilo got %h want %h", name, {hi, lo}, e);
         else passed++;
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      mdu_opcode = MDU_MFHI;
      total++;
      if ({busy, hi, lo, result} !== 97'd0)
         $display("FAIL reset got busy=%b hi=%h lo=%h result=%h want all 0", busy, hi, lo, result);
      else passed++;
      mdu_opcode = MDU_NOP;
      m_hilo = '0;
   endtask

   task automatic test_mult;
      push_exp(MDU_MULT, 32'hFFFF_FFFE, 32'h3, {32'hFFFF_FFFF, 32'hFFFF_FFFA});
      wait_done("mult", MULT_CYCLES_DEF, 1'b0);
   endtask

   task automatic test_back_to_back;
      push_exp(MDU_MULTU, 32'hFFFF_FFFE, 32'h3, {32'h2, 32'hFFFF_FFFA});
      wait_done("multu", MULT_CYCLES_DEF, 1'b0);
      // Issued in the very first idle cycle.
      push_exp(MDU_DIVU, 32'd100, 32'd7, {32'd2, 32'd14});
      wait_done("divu_b2b", DIV_CYCLES_DEF, 1'b0);
   endtask

   task automatic test_div;
      push_exp(MDU_DIV, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
      wait_done("div_neg", DIV_CYCLES_DEF, 1'b0);
      push_exp(MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, {32'd0, 32'h8000_0000});
      wait_done("div_ovf", DIV_CYCLES_DEF, 1'b0);
   endtask

   task automatic test_move;
      issue(MDU_MTHI, 32'h1234_5678, 32'd0);
      total++;
      if (hi !== 32'h1234_5678 || busy !== 1'b0)
         $display("FAIL mthi got hi=%h busy=%b want 12345678 0", hi, busy);
      else passed++;
      mdu_opcode = MDU_MFHI;
      #1;
      total++;
      if (result !== 32'h1234_5678) $display("FAIL mfhi result got %h want 12345678", result);
      else passed++;
      @(negedge clk);
      issue(MDU_MTHI, 32'h11, 32'd0);
      issue(MDU_MTLO, 32'h22, 32'd0);
      mdu_opcode = MDU_MFLO;
      #1;
      total++;
      if (result !== 32'h22 || hi !== 32'h11) $display("FAIL mflo result got %h hi=%h want 22 11", result, hi);
      else passed++;
      mdu_opcode = MDU_NOP;
      #1;
      total++;
      if (result !== 32'd0) $display("FAIL nop result got %h want 0", result);
      else passed++;
      @(negedge clk);
      m_hilo = {32'h11, 32'h22};
   endtask

   task automatic test_div_zero;
      push_exp(MDU_DIVU, 32'd5, 32'd0, {32'h11, 32'h22});
      wait_done("divu_zero", DIV_CYCLES_DEF, 1'b0);
   endtask

   task automatic test_busy_ignore;
      push_exp(MDU_MULT, 32'd7, 32'hFFFF_FFF7, {32'hFFFF_FFFF, 32'hFFFF_FFC1});
      wait_done("busy_ignore", MULT_CYCLES_DEF, 1'b1);
      total++;
      if (busy !== 1'b0) $display("FAIL busy_ignore busy after done got %b want 0", busy);
      else passed++;
   endtask

   task automatic test_random;
      logic [3:0] op;
      logic [31:0] x, y;
      for (int i = 0; i < 8; i++) begin
         op = 4'($urandom_range(1, 4));
         x = $urandom;
         y = (i == 5) ? 32'd0 : ((i % 2) ? $urandom : 32'($urandom_range(1, 300)));
         push_model(op, x, y);
         wait_done("random", (op == MDU_DIV || op == MDU_DIVU) ? DIV_CYCLES_DEF : MULT_CYCLES_DEF, 1'b0);
      end
   endtask

   task automatic test_reset_abort;
      bit stay0 = 1'b1;
      issue(MDU_MULT, 32'd3, 32'd4);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      m_hilo = '0;
      total++;
      if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0)
         $display("FAIL reset_abort got busy=%b hi=%h lo=%h want 0 0 0", busy, hi, lo);
      else passed++;
      repeat (6) begin
         @(negedge clk);
         if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) stay0 = 1'b0;
      end
      total++;
      if (!stay0) $display("FAIL reset_abort_nocommit got hi=%h lo=%h want 0 0", hi, lo);
      else passed++;
   endtask

   initial begin
      @(negedge clk);
      test_reset;
      test_mult;
      test_back_to_back;
      test_div;
      test_move;
      test_div_zero;
      test_busy_ignore;
      test_random;
      test_reset_abort;
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
